// File: rtl/rcp_rate_ctrl_pkg.sv
// Shared definitions for the RCP rate controller: FSM encoding, idle rate,
// and the helpers that locate a port's slice in the flat counter buses.
package rcp_rate_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNAP   = 3'd1,
        ST_DELTA  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [31:0] RATE_INIT_DEFAULT = 32'hFFFF_FFFF;
    localparam int          MIN_INTERVAL      = 16;
    localparam int          BYTE_W            = 64;
    localparam int          RCP_W             = 32;
    localparam int          RATE_W            = 32;

    function automatic int byte_lo(input int p);
        return p * BYTE_W;
    endfunction

    function automatic int rcp_lo(input int p);
        return p * RCP_W;
    endfunction

    // Wrap-safe 64-bit byte delta, saturated to 32 bits.
    function automatic logic [31:0] sat_delta(input logic [63:0] snap,
                                              input logic [63:0] prev);
        logic [63:0] d;
        d = snap - prev;
        return (d[63:32] != 32'd0) ? 32'hFFFF_FFFF : d[31:0];
    endfunction

endpackage

// File: rtl/rcp_rate_calc.sv
// Next-rate arithmetic for one port: spare-capacity feedback with an
// arithmetic-shift gain, clamped to [rate_min, rate_max].
module rcp_rate_calc
    import rcp_rate_ctrl_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2
) (
    input  logic [RATE_W-1:0] db,
    input  logic [RATE_W-1:0] dn,
    input  logic [RATE_W-1:0] capacity,
    input  logic [RATE_W-1:0] rate_min,
    input  logic [RATE_W-1:0] rate_max,
    input  logic [RATE_W-1:0] rate,
    output logic [RATE_W-1:0] rate_next
);

    logic signed [32:0] spare;
    logic signed [32:0] adj_33;
    logic signed [34:0] adj;
    logic signed [34:0] sum;
    logic signed [34:0] hi;
    logic signed [34:0] lo;

    always_comb begin
        spare  = $signed({1'b0, capacity}) - $signed({1'b0, db});
        adj_33 = spare >>> ALPHA_SHIFT;
        adj    = {{2{adj_33[32]}}, adj_33};
        sum    = $signed({3'b000, rate}) + adj;
        hi     = $signed({3'b000, rate_max});
        lo     = $signed({3'b000, rate_min});

        // The lower clamp is applied last so rate_min wins on inverted limits.
        if (dn == 32'd0) begin
            rate_next = rate_max;
        end else if (sum > hi) begin
            rate_next = (rate_min > rate_max) ? rate_min : rate_max;
        end else if (sum < lo) begin
            rate_next = rate_min;
        end else begin
            rate_next = sum[31:0];
        end
    end

endmodule

// File: rtl/rcp_rate_ctrl.sv
// Per-interval RCP rate producer: snapshots cumulative byte/packet counters,
// forms per-port deltas and walks the ports one at a time to update rates.
module rcp_rate_ctrl
    import rcp_rate_ctrl_pkg::*;
#(
    parameter int          NUM_PORTS   = 4,
    parameter int          ALPHA_SHIFT = 2,
    parameter logic [31:0] RATE_INIT   = RATE_INIT_DEFAULT,
    parameter int          TIMER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [TIMER_WIDTH-1:0]    interval_cycles,
    input  logic [31:0]               capacity,
    input  logic [31:0]               rate_min,
    input  logic [31:0]               rate_max,
    input  logic [NUM_PORTS*64-1:0]   num_byte_in,
    input  logic [NUM_PORTS*32-1:0]   num_rcp_in,
    output logic [NUM_PORTS*32-1:0]   rate_out,
    output logic                      rate_upd,
    output logic                      busy,
    output logic [31:0]               overrun_cnt
);

    localparam int            PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    state_t state;
    state_t state_next;

    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] reload;
    logic                   expire;

    logic          primed;
    logic [PW-1:0] p;
    logic [31:0]   db_q;
    logic [31:0]   dn_q;
    logic [31:0]   rate_next;

    logic [63:0] in_b   [NUM_PORTS];
    logic [31:0] in_n   [NUM_PORTS];
    logic [63:0] snap_b [NUM_PORTS];
    logic [31:0] snap_n [NUM_PORTS];
    logic [63:0] prev_b [NUM_PORTS];
    logic [31:0] prev_n [NUM_PORTS];
    logic [31:0] rate   [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_b[i]                  = num_byte_in[byte_lo(i) +: 64];
            in_n[i]                  = num_rcp_in[rcp_lo(i) +: 32];
            rate_out[rcp_lo(i) +: 32] = rate[i];
        end
    end

    // Very short intervals could starve the update pass; floor at 16 cycles.
    assign reload = (interval_cycles < TIMER_WIDTH'(MIN_INTERVAL))
                    ? TIMER_WIDTH'(MIN_INTERVAL) : interval_cycles;
    assign expire = enable && (timer <= TIMER_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer       <= reload;
            overrun_cnt <= 32'd0;
        end else begin
            if (!enable || expire) begin
                timer <= reload;
            end else begin
                timer <= timer - TIMER_WIDTH'(1);
            end
            if (expire && (state != ST_IDLE) && (overrun_cnt != 32'hFFFF_FFFF)) begin
                overrun_cnt <= overrun_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (expire) state_next = ST_SNAP;
                ST_SNAP:   state_next = primed ? ST_DELTA : ST_IDLE;
                ST_DELTA:  state_next = ST_UPDATE;
                ST_UPDATE: state_next = (p == LAST_PORT) ? ST_DONE : ST_DELTA;
                ST_DONE:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        rate_upd = (state == ST_DONE);
    end

    rcp_rate_calc #(
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_calc (
        .db        (db_q),
        .dn        (dn_q),
        .capacity  (capacity),
        .rate_min  (rate_min),
        .rate_max  (rate_max),
        .rate      (rate[p]),
        .rate_next (rate_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= 1'b0;
            p      <= '0;
            db_q   <= 32'd0;
            dn_q   <= 32'd0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                snap_b[i] <= 64'd0;
                snap_n[i] <= 32'd0;
                prev_b[i] <= 64'd0;
                prev_n[i] <= 32'd0;
                rate[i]   <= RATE_INIT;
            end
        end else if (!enable) begin
            primed <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rate[i] <= rate_max;
            end
        end else begin
            case (state)
                ST_SNAP: begin
                    p <= '0;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        snap_b[i] <= in_b[i];
                        snap_n[i] <= in_n[i];
                    end
                    // First pass after enable only establishes the baseline.
                    if (!primed) begin
                        primed <= 1'b1;
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            prev_b[i] <= in_b[i];
                            prev_n[i] <= in_n[i];
                        end
                    end
                end
                ST_DELTA: begin
                    db_q <= sat_delta(snap_b[p], prev_b[p]);
                    dn_q <= snap_n[p] - prev_n[p];
                end
                ST_UPDATE: begin
                    rate[p]   <= rate_next;
                    prev_b[p] <= snap_b[p];
                    prev_n[p] <= snap_n[p];
                    p         <= p + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
